mp_alu_seq: RTL and testbench
=============================

Name: mp_alu_seq

Overview:
- Multi-byte arithmetic sequencer that acts as the initiator for the 8-bit ALU.
- Accepts one wide command per Start handshake and issues one ALU byte operation per cycle: Aluop, DatA, DatB, CarryIn, Z, L, F.
- Captures Rslt, SCo, Zero and LessThan at each clock edge and chains the carry/borrow across bytes.
- Sits between the control unit and the ALU for wide adds, shifts and compares.

Parameters:
- NBYTES, 2, operand width in bytes; legal range 1..8; operand width W = 8*NBYTES.

Ports:
- Clk  in  1  clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  command request; sampled only in IDLE.
- Cmd  in  2  0=ADD, 1=LSL1, 2=CMP (unsigned), 3=SCMP (see Optional Feature).
- OpA  in  W  operand A; captured when Start is accepted.
- OpB  in  W  operand B; captured when Start is accepted; ignored for LSL1.
- Busy  out  1  high from the cycle after acceptance through the last RUN cycle.
- Done  out  1  one-cycle completion pulse.
- Result  out  W  ADD/LSL1 result; holds until the next ADD/LSL1 completes.
- CarryOut  out  1  final SCo for ADD/LSL1; 0 after CMP/SCMP.
- Less  out  1  compare result, A<B.
- Equal  out  1  compare result, A==B.
- Aluop  out  4  ALU opcode.
- DatA  out  8  ALU operand A byte.
- DatB  out  8  ALU operand B byte.
- CarryIn  out  1  ALU carry input.
- Z  out  1  ALU flag input; tied 0.
- L  out  1  ALU flag input; tied 0.
- F  out  1  ALU flag input; tied 0.
- Rslt  in  8  ALU result.
- SCo  in  1  ALU carry out.
- Zero  in  1  ALU zero flag.
- LessThan  in  1  ALU less-than flag.

Behaviour:
- Reset (any state, including mid-RUN):
  - state=IDLE; Busy=0, Done=0.
  - Result=0, CarryOut=0, Less=0, Equal=0; byte index=0; carry register=0.
  - No Done pulse is generated for an aborted command.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - ALU outputs are Aluop=0 (no-op), DatA=0, DatB=0, CarryIn=0.
  - Start=1 latches Cmd, OpA and OpB, and moves to RUN.
  - ADD/LSL1 set index=0. CMP/SCMP set index=NBYTES-1.
- RUN: ALU outputs are combinational from the registered state. DatA=A byte[index], DatB=B byte[index].
  - ADD:
    - LSB first. Byte 0 uses Aluop=1 with CarryIn=0; later bytes use Aluop=11 with CarryIn=carry register.
    - Each edge: Result byte[index]=Rslt, carry register=SCo, index+1.
  - LSL1:
    - LSB first. Aluop=4, DatB=1, CarryIn=carry register (0 on byte 0).
    - Result byte[index]=Rslt, carry register=SCo.
  - CMP:
    - MSB first, Aluop=7.
    - If Zero=0: Less=LessThan, Equal=0, go to DONE immediately (early exit).
    - If Zero=1 on byte 0: Less=0, Equal=1, go to DONE.
    - Otherwise index-1.
  - Leaving RUN: ADD/LSL1 leave after byte NBYTES-1 with CarryOut=carry register. CMP/SCMP set CarryOut=0.
- DONE: Done=1 for exactly one cycle with Busy=0, then IDLE. Start is ignored in DONE.
- Latency:
  - ADD/LSL1: fixed. Done is high NBYTES+1 cycles after the accepting edge.
  - CMP: k+1 cycles, where k = number of bytes examined (1..NBYTES).
- Start while Busy or in DONE is ignored with no queueing.
- Result is untouched by CMP/SCMP. Less/Equal are untouched by ADD/LSL1.
- Arithmetic is unsigned modulo 2^W. The final carry appears only on CarryOut.

Optional Feature:
- Macro: MP_SIGNED_CMP_EN.
- Defined:
  - Cmd=3 is SCMP. The MSB byte uses Aluop=8 (signed compare); lower bytes use Aluop=7 (unsigned).
  - Early-exit and equality rules are the same as CMP.
- Undefined: Cmd=3 behaves exactly as CMP, and Aluop=8 is never issued.

Test Plan:
- ADD, OpA=0x00FF, OpB=0x0001 (NBYTES=2) -> Aluop 1 then 11. Result=0x0100, CarryOut=0, Done exactly 3 cycles after the Start edge, Busy high for 2 cycles.
- ADD, OpA=0xFFFF, OpB=0x0001 -> Result=0x0000, CarryOut=1. Then LSL1, OpA=0x80C0 -> Result=0x0180, CarryOut=1.
- CMP, 0x1234 vs 0x1300 -> Less=1, Equal=0, Done after 1 RUN cycle. CMP, 0xABCD vs 0xABCD -> Equal=1, Less=0, Done after 2 RUN cycles. Result unchanged from the previous test.
- Start pulsed every cycle during an ADD -> only the first command executes, exactly one Done pulse. Then Reset=1 during RUN of a new ADD -> Busy=0 and all outputs 0 next cycle, no Done.
- SCMP, 0xFF00 vs 0x0100 -> with MP_SIGNED_CMP_EN, Less=1 and Aluop=8 seen once. Without the macro, Less=0 and Aluop=8 is never issued.
- NBYTES=1 build: ADD 0xF0+0x20 -> Result=0x10, CarryOut=1, Done 2 cycles after Start.

Source files
------------

// File: rtl/mp_alu_seq_if.sv
// Bundle between the control unit, the mp_alu_seq sequencer and the 8-bit ALU.
// The sequencer uses the slave modport; the control unit and ALU side use master.
interface mp_alu_seq_if #(
    parameter int NBYTES = 2
);
    localparam int W = 8 * NBYTES;

    logic         Start;
    logic [1:0]   Cmd;
    logic [W-1:0] OpA;
    logic [W-1:0] OpB;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic         CarryOut;
    logic         Less;
    logic         Equal;
    logic [3:0]   Aluop;
    logic [7:0]   DatA;
    logic [7:0]   DatB;
    logic         CarryIn;
    logic         Z;
    logic         L;
    logic         F;
    logic [7:0]   Rslt;
    logic         SCo;
    logic         Zero;
    logic         LessThan;

    modport slave (
        input  Start, Cmd, OpA, OpB, Rslt, SCo, Zero, LessThan,
        output Busy, Done, Result, CarryOut, Less, Equal,
        output Aluop, DatA, DatB, CarryIn, Z, L, F
    );

    modport master (
        output Start, Cmd, OpA, OpB, Rslt, SCo, Zero, LessThan,
        input  Busy, Done, Result, CarryOut, Less, Equal,
        input  Aluop, DatA, DatB, CarryIn, Z, L, F
    );
endinterface

// File: rtl/mp_alu_seq.sv
// Multi-byte ADD / LSL1 / compare sequencer driving an 8-bit ALU one byte per cycle.
// Optional macro MP_SIGNED_CMP_EN turns Cmd=3 into a signed compare (SCMP).
module mp_alu_seq #(
    parameter int NBYTES = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    mp_alu_seq_if.slave  bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    localparam logic [1:0] CMD_LSL1 = 2'd1;
    localparam logic [1:0] CMD_SCMP = 2'd3;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_LSL  = 4'd4;
    localparam logic [3:0] OP_UCMP = 4'd7;
    localparam logic [3:0] OP_SCMP = 4'd8;
    localparam logic [3:0] OP_ADC  = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t       r_state;
    state_t       w_next;
    logic [1:0]   r_cmd;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [IW-1:0] r_idx;
    logic         r_carry;
    logic [W-1:0] r_result;
    logic         r_carry_out;
    logic         r_less;
    logic         r_equal;

    logic         w_is_cmp;
    logic         w_last;
    logic         w_accept;
    logic [7:0]   w_a_byte;
    logic [7:0]   w_b_byte;

    // Cmd codes 2 and 3 are both compares; bit 1 alone tells them apart from ADD/LSL1.
    assign w_is_cmp = r_cmd[1];
    assign w_last   = (r_idx == LAST);
    assign w_accept = (r_state == S_IDLE) && bus.Start;

    always_comb begin
        w_a_byte = 8'd0;
        w_b_byte = 8'd0;
        for (int i = 0; i < NBYTES; i++) begin
            if (int'(r_idx) == i) begin
                w_a_byte = r_a[8*i +: 8];
                w_b_byte = r_b[8*i +: 8];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        bus.Busy    = 1'b0;
        bus.Done    = 1'b0;
        bus.Aluop   = OP_NOP;
        bus.DatA    = 8'd0;
        bus.DatB    = 8'd0;
        bus.CarryIn = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Start) w_next = S_RUN;
            end
            S_RUN: begin
                bus.Busy = 1'b1;
                bus.DatA = w_a_byte;
                bus.DatB = w_b_byte;
                if (w_is_cmp) begin
                    bus.Aluop = OP_UCMP;
`ifdef MP_SIGNED_CMP_EN
                    if (r_cmd == CMD_SCMP && w_last) bus.Aluop = OP_SCMP;
`endif
                    // Compare walks MSB first and stops at the first differing byte.
                    if (!bus.Zero || r_idx == '0) w_next = S_DONE;
                end else begin
                    if (r_cmd == CMD_LSL1) begin
                        bus.Aluop   = OP_LSL;
                        bus.DatB    = 8'd1;
                        bus.CarryIn = r_carry;
                    end else if (r_idx == '0) begin
                        bus.Aluop   = OP_ADD;
                    end else begin
                        bus.Aluop   = OP_ADC;
                        bus.CarryIn = r_carry;
                    end
                    if (w_last) w_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.Done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_cmd <= bus.Cmd;
            r_a   <= bus.OpA;
            r_b   <= bus.OpB;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_less      <= 1'b0;
            r_equal     <= 1'b0;
        end else if (w_accept) begin
            r_carry <= 1'b0;
            r_idx   <= bus.Cmd[1] ? LAST : '0;
        end else if (r_state == S_RUN) begin
            if (!w_is_cmp) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (int'(r_idx) == i) r_result[8*i +: 8] <= bus.Rslt;
                end
                r_carry <= bus.SCo;
                r_idx   <= r_idx + 1'b1;
                if (w_last) r_carry_out <= bus.SCo;
            end else if (!bus.Zero) begin
                r_less      <= bus.LessThan;
                r_equal     <= 1'b0;
                r_carry_out <= 1'b0;
            end else if (r_idx == '0) begin
                r_less      <= 1'b0;
                r_equal     <= 1'b1;
                r_carry_out <= 1'b0;
            end else begin
                r_idx <= r_idx - 1'b1;
            end
        end
    end

    assign bus.Result   = r_result;
    assign bus.CarryOut = r_carry_out;
    assign bus.Less     = r_less;
    assign bus.Equal    = r_equal;
    assign bus.Z        = 1'b0;
    assign bus.L        = 1'b0;
    assign bus.F        = 1'b0;
endmodule

// File: tb/tb_mp_alu_seq.sv
// Directed bench for mp_alu_seq: a behavioural 8-bit ALU answers each byte operation,
// and a second NBYTES=1 instance covers the single-byte build.
module tb_mp_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mp_alu_seq_if #(.NBYTES(2)) u_if ();
    mp_alu_seq_if #(.NBYTES(1)) u1_if ();

    mp_alu_seq #(.NBYTES(2)) u_dut  (.Clk(clk), .Reset(rst), .bus(u_if.slave));
    mp_alu_seq #(.NBYTES(1)) u_dut1 (.Clk(clk), .Reset(rst), .bus(u1_if.slave));

    function automatic logic [10:0] alu(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
        logic [8:0] s;
        logic       lt;
        logic       zr;
        s  = 9'd0;
        lt = 1'b0;
        case (op)
            4'd1:    s = {1'b0, a} + {1'b0, b};
            4'd11:   s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            4'd4:    s = {a, cin};
            4'd7:    lt = (a < b);
            4'd8:    lt = ($signed(a) < $signed(b));
            default: s = 9'd0;
        endcase
        zr = (op == 4'd7 || op == 4'd8) ? (a == b) : (s[7:0] == 8'd0);
        return {s[8], zr, lt, s[7:0]};
    endfunction

    always_comb {u_if.SCo, u_if.Zero, u_if.LessThan, u_if.Rslt} =
        alu(u_if.Aluop, u_if.DatA, u_if.DatB, u_if.CarryIn);
    always_comb {u1_if.SCo, u1_if.Zero, u1_if.LessThan, u1_if.Rslt} =
        alu(u1_if.Aluop, u1_if.DatA, u1_if.DatB, u1_if.CarryIn);

    int n_vec = 0;
    int n_err = 0;

    int         done_cyc;
    int         n_done;
    int         busy_cnt;
    int         op8_cnt;
    logic [3:0] ops [1:12];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command on the 2-byte instance and watches 12 cycles after the accept edge.
    task automatic run(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] b,
                       input int hold);
        @(negedge clk);
        u_if.Start = 1'b1;
        u_if.Cmd   = cmd;
        u_if.OpA   = a;
        u_if.OpB   = b;
        @(posedge clk);
        done_cyc = -1;
        n_done   = 0;
        busy_cnt = 0;
        op8_cnt  = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            ops[c] = u_if.Aluop;
            if (u_if.Aluop == 4'd8) op8_cnt++;
            if (u_if.Busy) busy_cnt++;
            if (u_if.Done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            u_if.Start = (c <= hold);
        end
    endtask

    initial begin
        u_if.Start  = 1'b0;
        u_if.Cmd    = 2'd0;
        u_if.OpA    = '0;
        u_if.OpB    = '0;
        u1_if.Start = 1'b0;
        u1_if.Cmd   = 2'd0;
        u1_if.OpA   = '0;
        u1_if.OpB   = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy",   u_if.Busy,     0);
        chk("rst_done",   u_if.Done,     0);
        chk("rst_result", u_if.Result,   0);
        chk("rst_cout",   u_if.CarryOut, 0);
        chk("rst_less",   u_if.Less,     0);
        chk("rst_equal",  u_if.Equal,    0);
        chk("rst_aluop",  u_if.Aluop,    0);
        rst = 1'b0;

        run(2'd0, 16'h00FF, 16'h0001, 0);
        chk("add1_op0",    ops[1],        4'd1);
        chk("add1_op1",    ops[2],        4'd11);
        chk("add1_result", u_if.Result,   16'h0100);
        chk("add1_cout",   u_if.CarryOut, 0);
        chk("add1_donecy", done_cyc,      3);
        chk("add1_ndone",  n_done,        1);
        chk("add1_busy",   busy_cnt,      2);

        run(2'd0, 16'hFFFF, 16'h0001, 0);
        chk("add2_result", u_if.Result,   16'h0000);
        chk("add2_cout",   u_if.CarryOut, 1);

        run(2'd1, 16'h80C0, 16'h0000, 0);
        chk("lsl_op0",    ops[1],        4'd4);
        chk("lsl_result", u_if.Result,   16'h0180);
        chk("lsl_cout",   u_if.CarryOut, 1);
        chk("lsl_donecy", done_cyc,      3);

        run(2'd2, 16'h1234, 16'h1300, 0);
        chk("cmp1_less",   u_if.Less,     1);
        chk("cmp1_equal",  u_if.Equal,    0);
        chk("cmp1_donecy", done_cyc,      2);
        chk("cmp1_busy",   busy_cnt,      1);
        chk("cmp1_cout",   u_if.CarryOut, 0);
        chk("cmp1_result", u_if.Result,   16'h0180);

        run(2'd2, 16'h1234, 16'h1233, 0);
        chk("cmp2_less",   u_if.Less,  0);
        chk("cmp2_equal",  u_if.Equal, 0);
        chk("cmp2_donecy", done_cyc,   3);

        run(2'd2, 16'hABCD, 16'hABCD, 0);
        chk("cmp3_less",   u_if.Less,   0);
        chk("cmp3_equal",  u_if.Equal,  1);
        chk("cmp3_donecy", done_cyc,    3);
        chk("cmp3_busy",   busy_cnt,    2);
        chk("cmp3_result", u_if.Result, 16'h0180);

        run(2'd0, 16'h0001, 16'h0002, 3);
        chk("hold_ndone",  n_done,      1);
        chk("hold_busy",   busy_cnt,    2);
        chk("hold_result", u_if.Result, 16'h0003);
        chk("hold_equal",  u_if.Equal,  1);
        chk("hold_less",   u_if.Less,   0);

        @(negedge clk);
        u_if.Start = 1'b1;
        u_if.Cmd   = 2'd0;
        u_if.OpA   = 16'h1111;
        u_if.OpB   = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        u_if.Start = 1'b0;
        chk("abort_busy_pre", u_if.Busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",   u_if.Busy,     0);
        chk("abort_done",   u_if.Done,     0);
        chk("abort_result", u_if.Result,   0);
        chk("abort_equal",  u_if.Equal,    0);
        chk("abort_aluop",  u_if.Aluop,    0);
        chk("abort_data",   u_if.DatA,     0);
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (u_if.Done) n_done++;
        end
        chk("abort_nodone", n_done, 0);

        run(2'd2, 16'h0001, 16'h0002, 0);
        chk("cmp4_less", u_if.Less, 1);

        run(2'd3, 16'hFF00, 16'h0100, 0);
        chk("scmp_donecy", done_cyc, 2);
`ifdef MP_SIGNED_CMP_EN
        chk("scmp_less", u_if.Less, 1);
        chk("scmp_op8",  op8_cnt,   1);
`else
        chk("scmp_less", u_if.Less, 0);
        chk("scmp_op8",  op8_cnt,   0);
`endif

        @(negedge clk);
        u1_if.Start = 1'b1;
        u1_if.Cmd   = 2'd0;
        u1_if.OpA   = 8'hF0;
        u1_if.OpB   = 8'h20;
        @(posedge clk);
        done_cyc = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            u1_if.Start = 1'b0;
            if (u1_if.Done && done_cyc < 0) done_cyc = c;
        end
        chk("b1_result", u1_if.Result,   8'h10);
        chk("b1_cout",   u1_if.CarryOut, 1);
        chk("b1_donecy", done_cyc,       2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
